// File: rtl/cla_seq_adder_pkg.sv
// Shared types and constants for the slice-serial carry-lookahead adder.
package cla_seq_adder_pkg;

    localparam int SLICE_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic int idx_width(input int nslice);
        return (nslice > 1) ? $clog2(nslice) : 1;
    endfunction

endpackage

// File: rtl/cla_seq_adder_if.sv
// Operand request / result response bundle for cla_seq_adder.
interface cla_seq_adder_if #(parameter int WIDTH = 32);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    modport master (
        output in_valid, a, b, cin, sub, out_ready,
        input  in_ready, out_valid, sum, cout, ovf
    );

    modport slave (
        input  in_valid, a, b, cin, sub, out_ready,
        output in_ready, out_valid, sum, cout, ovf
    );

endinterface

// File: rtl/cla_seq_adder_cla_block.sv
// 4-bit carry-lookahead unit: every carry is a flat function of P, G and ci.
module cla_block (
    input  logic [3:0] p,
    input  logic [3:0] g,
    input  logic       ci,
    output logic [4:0] c
);

    assign c[0] = ci;
    assign c[1] = g[0] | (p[0] & ci);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                | (p[2] & p[1] & p[0] & ci);
    assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                | (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & ci);

endmodule

// File: rtl/cla_seq_adder.sv
// Slice-serial adder/subtractor: one 4-bit lookahead slice per cycle, result
// registered and held until the consumer takes it.
module cla_seq_adder
    import cla_seq_adder_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic           clk,
    input  logic           rst_n,
    cla_seq_adder_if.slave bus
);

    localparam int NSLICE = WIDTH / SLICE_W;
    localparam int IW     = idx_width(NSLICE);
    localparam logic [IW-1:0] LAST = IW'(NSLICE - 1);

    state_t state, state_nxt;

    logic [IW-1:0]             idx;
    logic [WIDTH-1:0]          a_sh, b_sh;
    logic [WIDTH-SLICE_W-1:0]  acc;
    logic [WIDTH-1:0]          sum_q;
    logic                      carry, cout_q, ovf_q;
    logic [SLICE_W-1:0]        p, g, s;
    logic [SLICE_W:0]          c;
    logic                      accept, last;

    assign p = a_sh[SLICE_W-1:0] ^ b_sh[SLICE_W-1:0];
    assign g = a_sh[SLICE_W-1:0] & b_sh[SLICE_W-1:0];
    assign s = p ^ c[SLICE_W-1:0];

    cla_block u_cla (
        .p  (p),
        .g  (g),
        .ci (carry),
        .c  (c)
    );

    assign accept = (state == IDLE) && bus.in_valid;
    assign last   = (idx == LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.in_valid)  state_nxt = RUN;
            RUN:     if (last)          state_nxt = DONE;
            DONE:    if (bus.out_ready) state_nxt = IDLE;
            default:                    state_nxt = IDLE;
        endcase
    end

    // Operands shift down so the active slice is always at bit 0; completed
    // slices shift into acc from the top and land in place after NSLICE steps.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx    <= '0;
            a_sh   <= '0;
            b_sh   <= '0;
            acc    <= '0;
            carry  <= 1'b0;
            sum_q  <= '0;
            cout_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else if (accept) begin
            idx   <= '0;
            a_sh  <= bus.a;
            b_sh  <= bus.sub ? ~bus.b : bus.b;
            carry <= bus.sub | bus.cin;
        end else if (state == RUN) begin
            a_sh  <= a_sh >> SLICE_W;
            b_sh  <= b_sh >> SLICE_W;
            acc   <= {s, acc[WIDTH-SLICE_W-1:SLICE_W]};
            carry <= c[SLICE_W];
            if (last) begin
                sum_q  <= {s, acc};
                cout_q <= c[SLICE_W];
                ovf_q  <= c[SLICE_W-1] ^ c[SLICE_W];
            end else begin
                idx <= idx + 1'b1;
            end
        end
    end

    assign bus.in_ready  = (state == IDLE);
    assign bus.out_valid = (state == DONE);
    assign bus.sum       = sum_q;
    assign bus.cout      = cout_q;
    assign bus.ovf       = ovf_q;

endmodule

// File: tb/tb_cla_seq_adder.sv
// Scoreboard bench for cla_seq_adder: driver pushes reference results, monitor pops on handshake.
module tb_cla_seq_adder;

    localparam int WIDTH  = 32;
    localparam int NSLICE = WIDTH / 4;

    typedef struct {
        logic [WIDTH-1:0] sum;
        logic             cout;
        logic             ovf;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    cla_seq_adder_if #(.WIDTH(WIDTH)) bus ();

    cla_seq_adder #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    exp_t sb_q[$];
    int   acc_q[$];
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    int   bp_mode = 0;

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: signed/unsigned arithmetic on wide integers.
    function automatic exp_t ref_add(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                     input logic ci, input logic sb);
        exp_t   r;
        logic [WIDTH:0] full;
        longint sa, sbv, res;
        longint lim = 2147483647;
        if (sb) begin
            full = {1'b0, a} + {1'b0, ~b} + 33'd1;
            sa   = longint'($signed(a));
            sbv  = longint'($signed(b));
            res  = sa - sbv;
        end else begin
            full = {1'b0, a} + {1'b0, b} + {32'd0, ci};
            sa   = longint'($signed(a));
            sbv  = longint'($signed(b));
            res  = sa + sbv + longint'(ci);
        end
        r.sum  = full[WIDTH-1:0];
        r.cout = full[WIDTH];
        r.ovf  = (res > lim) || (res < -lim - 1);
        return r;
    endfunction

    // Backpressure: 0 = always ready, 1 = random, 2 = held low.
    always @(posedge clk) begin
        #1;
        case (bp_mode)
            0:       bus.out_ready = 1'b1;
            1:       bus.out_ready = ($urandom_range(0, 3) != 0);
            default: bus.out_ready = 1'b0;
        endcase
    end

    logic             ov_prev = 1'b0;
    logic             hs_prev = 1'b0;
    logic [WIDTH-1:0] h_sum;
    logic [1:0]       h_flags;

    always @(negedge clk) begin
        if (!rst_n) begin
            ov_prev = 1'b0;
            hs_prev = 1'b0;
        end else begin
            if (bus.out_valid) begin
                chk("ready_in_done", {63'd0, bus.in_ready}, 64'd0);
                if (!ov_prev) begin
                    if (acc_q.size() == 0) chk("spurious_valid", 64'd1, 64'd0);
                    else                   chk("latency", 64'(cyc - acc_q.pop_front()), 64'(NSLICE));
                end else if (!hs_prev) begin
                    chk("hold_sum", {32'd0, bus.sum}, {32'd0, h_sum});
                    chk("hold_flags", {62'd0, bus.cout, bus.ovf}, {62'd0, h_flags});
                end
                h_sum   = bus.sum;
                h_flags = {bus.cout, bus.ovf};
                if (bus.out_ready) begin
                    if (sb_q.size() == 0) begin
                        chk("unexpected_result", 64'd1, 64'd0);
                    end else begin
                        exp_t e;
                        e = sb_q.pop_front();
                        chk("sum", {32'd0, bus.sum}, {32'd0, e.sum});
                        chk("cout", {63'd0, bus.cout}, {63'd0, e.cout});
                        chk("ovf", {63'd0, bus.ovf}, {63'd0, e.ovf});
                    end
                end
                hs_prev = bus.out_ready;
            end
            ov_prev = bus.out_valid;
        end
    end

    task automatic send(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        input logic ci, input logic sb);
        int n;
        @(negedge clk);
        bus.a = a; bus.b = b; bus.cin = ci; bus.sub = sb;
        bus.in_valid = 1'b1;
        n = 0;
        while (!bus.in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!bus.in_ready) begin
            chk("accept_timeout", {63'd0, bus.in_ready}, 64'd1);
        end else begin
            sb_q.push_back(ref_add(a, b, ci, sb));
            acc_q.push_back(cyc + 1);
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.a = $urandom; bus.b = $urandom;
        bus.cin = 1'($urandom); bus.sub = 1'($urandom);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb_q.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("drain_empty", 64'(sb_q.size()), 64'd0);
    endtask

    initial begin
        int n;
        bus.in_valid = 1'b0;
        bus.a = '0; bus.b = '0; bus.cin = 1'b0; bus.sub = 1'b0;
        #3;
        chk("rst_in_ready", {63'd0, bus.in_ready}, 64'd1);
        chk("rst_out_valid", {63'd0, bus.out_valid}, 64'd0);
        chk("rst_sum", {32'd0, bus.sum}, 64'd0);
        chk("rst_flags", {62'd0, bus.cout, bus.ovf}, 64'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // Directed corner vectors
        send(32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0);
        send(32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0);
        send(32'h5, 32'h7, 1'b1, 1'b1);
        send(32'h8000_0000, 32'h1, 1'b0, 1'b1);
        send(32'h0, 32'h0, 1'b0, 1'b1);
        send(32'h8000_0000, 32'h8000_0000, 1'b1, 1'b0);
        drain();

        // Result held under backpressure; in_valid during DONE ignored
        bp_mode = 2;
        @(posedge clk);
        #2;
        send(32'h0000_000F, 32'h0, 1'b1, 1'b0);
        n = 0;
        while (!bus.out_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("done_reached", {63'd0, bus.out_valid}, 64'd1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("busy_ready", {63'd0, bus.in_ready}, 64'd0);
            chk("held_sum", {32'd0, bus.sum}, 64'h10);
            bus.in_valid = (i == 2);
            bus.a = $urandom; bus.b = $urandom;
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        bp_mode = 0;
        @(posedge clk);
        #2;
        @(posedge clk);
        @(negedge clk);
        chk("idle_after_hs_ready", {63'd0, bus.in_ready}, 64'd1);
        chk("idle_after_hs_valid", {63'd0, bus.out_valid}, 64'd0);
        drain();

        // Reset pulsed while slice 3 is in flight
        send(32'hDEAD_BEEF, 32'h0000_0001, 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_sum", {32'd0, bus.sum}, 64'd0);
        chk("midrst_flags", {62'd0, bus.cout, bus.ovf}, 64'd0);
        chk("midrst_valid", {63'd0, bus.out_valid}, 64'd0);
        chk("midrst_ready", {63'd0, bus.in_ready}, 64'd1);
        sb_q.delete();
        acc_q.delete();
        @(posedge clk);
        #1 rst_n = 1'b1;
        send(32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0);
        drain();

        // Random traffic with random backpressure and gaps
        bp_mode = 1;
        for (int i = 0; i < 40; i++) begin
            send($urandom, $urandom, 1'($urandom), 1'($urandom));
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end
        bp_mode = 0;
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/cla_seq_adder.md
CLA_SEQ_ADDER -- requirements
Module: cla_seq_adder

Interface
REQ-001 SHALL have parameter WIDTH, default 32: operand width in bits; a multiple of 4, at least 8.
REQ-002 SHALL have derived constant NSLICE = WIDTH/4: slices per operation.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  reset; asynchronous assertion, active low.
REQ-005 in_valid  input  1  operand request.
REQ-006 in_ready  output  1  block can accept an operand request.
REQ-007 a  input  WIDTH  operand A.
REQ-008 b  input  WIDTH  operand B.
REQ-009 cin  input  1  carry-in; used only when sub=0.
REQ-010 sub  input  1  0 = A+B+cin; 1 = A+~B+1 (A-B).
REQ-011 out_valid  output  1  result available.
REQ-012 out_ready  input  1  consumer accepts the result.
REQ-013 sum  output  WIDTH  result.
REQ-014 cout  output  1  carry out of the MSB; for sub=1, 1 means no borrow.
REQ-015 ovf  output  1  two's-complement overflow.

Function
REQ-016 SHALL implement FSM states IDLE, RUN and DONE.
REQ-017 SHALL assert in_ready only in IDLE; out_valid only in DONE.
REQ-018 IDLE: on in_valid&in_ready, SHALL capture operands and enter RUN with slice index 0.
  - Captured: a; b, or ~b when sub=1.
  - Carry register loaded with cin, or with 1 when sub=1.
REQ-019 SHALL process slice k (bits 4k+3:4k) in each RUN cycle through the 4-bit lookahead unit.
  - P = a_k^b_k; G = a_k&b_k; carry-in = carry register.
  - sum_k <= P ^ C[3:0]; carry register <= C[4].
REQ-020 After slice NSLICE-1, SHALL enter DONE and latch:
  - cout = C[4];
  - ovf = C[3]^C[4] of the last slice.
REQ-021 Latency: out_valid SHALL rise exactly NSLICE cycles after the accepting edge (8 for WIDTH=32).
REQ-022 DONE: sum/cout/ovf SHALL hold stable until out_valid&out_ready, then the FSM SHALL return to IDLE.
  - No in_valid accept occurs on the DONE->IDLE edge; the next accept is possible one cycle later.
REQ-023 in_valid in RUN or DONE SHALL be ignored; operand inputs SHALL not affect an operation in flight.
REQ-024 Slice index SHALL count 0..NSLICE-1 and SHALL never wrap inside an operation.
REQ-025 Throughput: at most one operation per NSLICE+2 cycles with out_ready held high.

Reset
REQ-026 rst_n low SHALL force, asynchronously:
  - FSM to IDLE;
  - sum, cout, ovf, carry register and slice index to 0;
  - out_valid=0, in_ready=1.
REQ-027 Reset mid-RUN or mid-DONE SHALL discard the operation; no partial result is ever presented.
REQ-028 After rst_n deasserts, the first accept SHALL be possible on the first rising edge.

Structure
REQ-029 Shared package SHALL hold the FSM state enum (2 bits) and slice width constant 4.
REQ-030 SHALL instantiate exactly one sub-module: cla_block (4-bit lookahead carry unit; P, G, cin in; C[4:0] out).
  - Remaining logic: FSM, slice counter, operand shift/select, result register.

Verification
REQ-031 a=0xFFFFFFFF, b=1, cin=0, sub=0 -> sum=0x00000000, cout=1, ovf=0; out_valid exactly 8 cycles after accept.
REQ-032 a=0x7FFFFFFF, b=1, sub=0 -> sum=0x80000000, cout=0, ovf=1.
REQ-033 a=5, b=7, sub=1, cin=1 (cin ignored) -> sum=0xFFFFFFFE, cout=0, ovf=0.
REQ-034 a=0x0000000F, b=0, cin=1, out_ready low 5 cycles:
  - sum=0x00000010 held stable throughout;
  - in_ready=0 and a concurrent in_valid pulse ignored;
  - IDLE one cycle after out_ready rises.
REQ-035 rst_n pulsed low during slice 3 -> all outputs 0 immediately, in_ready=1; next op 0x12345678+0x11111111 -> 0x23456789 in 8 cycles.
